// File: rtl/grey_scan_rx.sv
// grey_scan_rx: receiver for the 5-bit walking-grey digit stream of the LED ring.
// Synchronises and debounces i_grey, decodes each accepted symbol, and reassembles
// DP,hundreds,tens,ones frames into BCD digits plus a 10-bit binary value.
module grey_scan_rx #(
  parameter int STABLE_CYCLES = 16,
  parameter int SYM_CYCLES    = 20001
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_grey,
  output logic       o_valid,
  output logic [3:0] o_100,
  output logic [3:0] o_010,
  output logic [3:0] o_001,
  output logic [9:0] o_bin,
  output logic       o_err,
  output logic       o_sync
);

  // Counter must reach the repeat-accept point without wrapping.
  localparam int CW = $clog2(STABLE_CYCLES + SYM_CYCLES + 1);
  localparam logic [CW-1:0] FIRST_ACC = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REP_ACC   = CW'(STABLE_CYCLES + SYM_CYCLES - 1);
  localparam logic [CW-1:0] RELOAD    = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    K_DIGIT = 2'd0,
    K_DP    = 2'd1,
    K_BLANK = 2'd2,
    K_ILL   = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] digit;
  } sym_t;

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_D100 = 3'd1,
    S_D010 = 3'd2,
    S_D001 = 3'd3,
    S_WDP  = 3'd4
  } state_e;

  // Map a raw ring code to its symbol class and digit value.
  function automatic sym_t decode(input logic [4:0] code);
    sym_t s;
    s.kind  = K_DIGIT;
    s.digit = 4'd0;
    case (code)
      5'b10001: s.digit = 4'd0;
      5'b00001: s.digit = 4'd1;
      5'b00011: s.digit = 4'd2;
      5'b00010: s.digit = 4'd3;
      5'b00110: s.digit = 4'd4;
      5'b00100: s.digit = 4'd5;
      5'b01100: s.digit = 4'd6;
      5'b01000: s.digit = 4'd7;
      5'b11000: s.digit = 4'd8;
      5'b10000: s.digit = 4'd9;
      5'b10101: s.kind  = K_DP;
      5'b00000: s.kind  = K_BLANK;
      default:  s.kind  = K_ILL;
    endcase
    return s;
  endfunction

  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [CW-1:0] r_cnt;
  state_e        r_state;
  logic [3:0]    r_h;
  logic [3:0]    r_t;

  logic          w_acc;
  sym_t          w_sym;
  state_e        w_state_nxt;
  logic          w_err;
  logic          w_ld_h;
  logic          w_ld_t;
  logic          w_ld_o;
  logic [9:0]    w_bin;

  assign w_sym = decode(r_sync2);
  // Accept once after the stable window, then once per symbol period while unchanged.
  assign w_acc = (r_cnt == FIRST_ACC) || (r_cnt == REP_ACC);

  // Shift-add conversion: h*100 = h*64+h*32+h*4, t*10 = t*8+t*2.
  assign w_bin = ({6'd0, r_h} << 6) + ({6'd0, r_h} << 5) + ({6'd0, r_h} << 2)
               + ({6'd0, r_t} << 3) + ({6'd0, r_t} << 1) + {6'd0, w_sym.digit};

  // Two-flop synchroniser for the asynchronous ring input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 5'd0;
      r_sync2 <= 5'd0;
    end else begin
      r_sync1 <= i_grey;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter: restarts on any change of the synced code, reloads after a repeat accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_sync1 != r_sync2) begin
      r_cnt <= '0;
    end else if (r_cnt == REP_ACC) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Frame FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM next-state and load/error decisions, evaluated only on an accept strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_ld_h      = 1'b0;
    w_ld_t      = 1'b0;
    w_ld_o      = 1'b0;
    if (w_acc) begin
      case (w_sym.kind)
        K_BLANK: w_state_nxt = S_HUNT;
        K_ILL: begin
          w_state_nxt = S_HUNT;
          w_err       = 1'b1;
        end
        K_DP: begin
          case (r_state)
            S_HUNT:  w_state_nxt = S_D100;
            S_WDP:   w_state_nxt = S_D100;
            S_D100, S_D010, S_D001: begin
              w_state_nxt = S_D100;
              w_err       = 1'b1;
            end
            default: w_state_nxt = S_HUNT;
          endcase
        end
        K_DIGIT: begin
          case (r_state)
            S_HUNT:  w_state_nxt = S_HUNT;
            S_D100: begin
              w_state_nxt = S_D010;
              w_ld_h      = 1'b1;
            end
            S_D010: begin
              w_state_nxt = S_D001;
              w_ld_t      = 1'b1;
            end
            S_D001: begin
              w_state_nxt = S_WDP;
              w_ld_o      = 1'b1;
            end
            S_WDP: begin
              w_state_nxt = S_HUNT;
              w_err       = 1'b1;
            end
            default: w_state_nxt = S_HUNT;
          endcase
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Internal digit holding registers; outputs only move when the ones digit completes a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= 4'd0;
      r_t <= 4'd0;
    end else begin
      if (w_ld_h) r_h <= w_sym.digit;
      if (w_ld_t) r_t <= w_sym.digit;
    end
  end

  // Registered outputs: frame result, pulses and sync level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_sync  <= 1'b0;
      o_100   <= 4'd0;
      o_010   <= 4'd0;
      o_001   <= 4'd0;
      o_bin   <= 10'd0;
    end else begin
      o_valid <= w_ld_o;
      o_err   <= w_err;
      o_sync  <= (w_state_nxt != S_HUNT);
      if (w_ld_o) begin
        o_100 <= r_h;
        o_010 <= r_t;
        o_001 <= w_sym.digit;
        o_bin <= w_bin;
      end
    end
  end

endmodule
